varredura_display: RTL and testbench
====================================

# varredura_display

- Time-multiplexed driver for a three-digit seven-segment display.
- Sits directly downstream of the combinational binary-to-BCD converter. It latches the `centenas`/`dezenas`/`unidades` digits on a load strobe into a shadow register and scans the three digits at a programmable rate.
- Drives one-hot anode enables and decoded segments, with a one-cycle blanking gap between digits to prevent ghosting.

## Interface
- `DIVISOR`, default 50000: clock cycles per digit slot, including the blank cycle; legal range ≥ 2.
- `ATIVO_BAIXO`, default 1: 1 inverts `segmentos` and `anodos` at the pins (active-low hardware); 0 makes them active-high.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `carregar` input 1: load strobe, sampled each rising edge.
- `centenas` input 4: BCD hundreds digit.
- `dezenas` input 4: BCD tens digit.
- `unidades` input 4: BCD units digit.
- `segmentos` output 7: segment outputs; bit0=a … bit6=g.
- `anodos` output 3: digit enables; bit0=units, bit1=tens, bit2=hundreds.

## Operation
- **Shadow register:** 3×4 bits, loaded from the inputs on any edge with `carregar`=1; otherwise held.
- **Prescaler:** `contador` runs 0..DIVISOR-1 and wraps. `tick` = (`contador`==DIVISOR-1).
- **Digit index:** `indice` sequence is 0 (units) → 1 (tens) → 2 (hundreds) → 0. It advances on the edge where `tick`=1.
- **Blank cycle:** on the edge where `tick`=1, outputs are registered as blank (all anodes and segments inactive). On every other edge, outputs are registered from `indice` and the shadow register.
- **Decode, active-high internal encoding:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10–15 shows a dash (40).
- **Polarity:** with `ATIVO_BAIXO`=1, both output buses are bitwise inverted after decode. "Inactive" means 1 on the pin.
- **Simultaneous load and tick:** both take effect on the same edge. The new shadow value is used from the first non-blank cycle of the next slot.
- **Reset:**
  - Shadow register = 000; `contador` = 0; `indice` = 0.
  - `segmentos` and `anodos` = inactive (all 1s when `ATIVO_BAIXO`=1).
  - Reset asserted mid-scan or mid-load overrides everything in that cycle. A load coincident with reset is discarded.

## Timing
- Load latency:
  - Shadow register updated at edge N, where `carregar`=1 at edge N.
  - Pins reflect the new value at edge N+1 if the current digit slot is not blank at that edge.
- Slot length: DIVISOR cycles, of which 1 is blank and DIVISOR-1 are lit.
- Full refresh period: 3×DIVISOR cycles.
- First edge after reset release: pins show units digit "0" (`anodos` bit0 active, `segmentos`=3F internal).
- `contador` and `indice` never stall. There is no backpressure, and `carregar` is accepted every cycle.

## Configuration
- `VARREDURA_LZB_EN` enables leading-zero blanking.
- **Defined:**
  - The hundreds slot is fully blank (anode inactive) when shadow `centenas`==0.
  - The tens slot is fully blank when `centenas`==0 and `dezenas`==0.
  - The units digit is always shown. Slot timing is unchanged.
- **Undefined:** all three digits are always displayed, including leading zeros.

## Structure
- **Shared package:**
  - The ten segment encodings plus the dash and blank constants.
  - `indice` encodings (`DIG_UNIDADES`/`DIG_DEZENAS`/`DIG_CENTENAS`).
  - A width function for `contador` (clog2 of DIVISOR).
- **Sub-module `decodificador_7seg`:** combinational BCD-to-segments (internal active-high encoding, dash for 10–15). Instantiated once and fed by a mux on `indice`.

## Test plan
All scenarios use DIVISOR=4, ATIVO_BAIXO=0 unless noted.
- **Reset:** hold `reset` for 3 cycles. During reset, `anodos`=000 and `segmentos`=00. On the first edge after release, `anodos`=001 and `segmentos`=3F.
- **Load 2/5/5, then observe 12 cycles:**
  - Units slot: 3 lit cycles of 001/6D.
  - Blank, then tens slot: 3 lit cycles of 010/6D.
  - Blank, then hundreds slot: 3 lit cycles of 100/5B.
  - Blank, then wrap to units.
- **Invalid digit:** load `unidades`=12 → units slot shows segments 40.
- **Simultaneous events:** assert `carregar` (1/2/3) on the tick edge, then assert `reset` mid-slot. The next slot shows the new value. The reset cycle forces outputs inactive, and `indice` restarts at units.
- **Leading-zero blanking** (`VARREDURA_LZB_EN` defined): load 0/0/7. The hundreds and tens slots show `anodos`=000 for all 4 cycles; the units slot shows 07.
- **Pin polarity** (`ATIVO_BAIXO`=1): load 0/0/8. The units lit cycle shows `anodos`=110 and `segmentos`=00. A blank cycle shows `anodos`=111 and `segmentos`=7F.

Source files
------------

// File: rtl/varredura_display_pkg.sv
// varredura_display_pkg
// Shared definitions for the three-digit seven-segment scanner:
//   - segment encodings (internal active-high, bit0=a .. bit6=g)
//   - digit index encodings used by the scan sequence
//   - width helper for the prescaler counter
package varredura_display_pkg;

  // Segment patterns, active-high, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0       = 7'h3F;
  localparam logic [6:0] SEG_1       = 7'h06;
  localparam logic [6:0] SEG_2       = 7'h5B;
  localparam logic [6:0] SEG_3       = 7'h4F;
  localparam logic [6:0] SEG_4       = 7'h66;
  localparam logic [6:0] SEG_5       = 7'h6D;
  localparam logic [6:0] SEG_6       = 7'h7D;
  localparam logic [6:0] SEG_7       = 7'h07;
  localparam logic [6:0] SEG_8       = 7'h7F;
  localparam logic [6:0] SEG_9       = 7'h6F;
  localparam logic [6:0] SEG_TRACO   = 7'h40;  // dash for non-BCD codes 10..15
  localparam logic [6:0] SEG_APAGADO = 7'h00;  // all segments off

  // Anode enables, active-high, bit0=units bit1=tens bit2=hundreds
  localparam logic [2:0] AN_APAGADO  = 3'b000;

  // Scan position; the value 3 is never reached
  typedef enum logic [1:0] {
    DIG_UNIDADES = 2'd0,
    DIG_DEZENAS  = 2'd1,
    DIG_CENTENAS = 2'd2
  } indice_t;

  // Bits needed to hold 0..divisor-1 (at least one bit)
  function automatic int largura_contador(input int divisor);
    if (divisor <= 2) begin
      return 1;
    end else begin
      return $clog2(divisor);
    end
  endfunction

endpackage

// File: rtl/varredura_display_if.sv
// varredura_display_if
// Groups the digit-load bus and the display pins of the scanner.
//   carregar                      : load strobe for the three digits
//   centenas / dezenas / unidades : BCD digits from the converter
//   segmentos                     : segment pins (bit0=a .. bit6=g)
//   anodos                        : digit enables (bit0=units .. bit2=hundreds)
// master = the side that supplies digits and watches the pins,
// slave  = the scanner itself.
interface varredura_display_if;

  logic       carregar;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;
  logic [6:0] segmentos;
  logic [2:0] anodos;

  modport master (
    output carregar, centenas, dezenas, unidades,
    input  segmentos, anodos
  );

  modport slave (
    input  carregar, centenas, dezenas, unidades,
    output segmentos, anodos
  );

endinterface

// File: rtl/varredura_display_decodificador_7seg.sv
// decodificador_7seg
// Combinational BCD to seven-segment decoder, internal active-high encoding.
//   bcd       : 4-bit digit; codes 10..15 produce a dash
//   segmentos : segment pattern, bit0=a .. bit6=g
module decodificador_7seg
  import varredura_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segmentos
);

  // Table lookup; anything outside 0..9 becomes a dash
  always_comb begin
    segmentos = SEG_TRACO;
    case (bcd)
      4'd0:    segmentos = SEG_0;
      4'd1:    segmentos = SEG_1;
      4'd2:    segmentos = SEG_2;
      4'd3:    segmentos = SEG_3;
      4'd4:    segmentos = SEG_4;
      4'd5:    segmentos = SEG_5;
      4'd6:    segmentos = SEG_6;
      4'd7:    segmentos = SEG_7;
      4'd8:    segmentos = SEG_8;
      4'd9:    segmentos = SEG_9;
      default: segmentos = SEG_TRACO;
    endcase
  end

endmodule

// File: rtl/varredura_display.sv
// varredura_display
// Time-multiplexed driver for a three-digit seven-segment display.
// Digits are latched into a shadow register on 'carregar' and scanned
// units -> tens -> hundreds, DIVISOR cycles per slot. The last cycle of
// every slot (the prescaler tick) is registered blank to avoid ghosting.
//
// Parameters:
//   DIVISOR     : clock cycles per digit slot including the blank (>= 2)
//   ATIVO_BAIXO : 1 = pins inverted (active-low hardware), 0 = active-high
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : varredura_display_if.slave (carregar, digits in; segmentos,
//           anodos out, both registered)
// Build option:
//   VARREDURA_LZB_EN : leading-zero blanking of the hundreds/tens slots
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter int DIVISOR     = 50000,
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  varredura_display_if.slave  bus
);

  localparam int             CW        = largura_contador(DIVISOR);
  localparam logic [CW-1:0]  CONT_MAX  = CW'(DIVISOR - 1);
  // XOR masks that move the internal active-high encoding onto the pins;
  // they are also the "inactive" pin values.
  localparam logic [6:0]     SEG_MASCARA = ATIVO_BAIXO ? 7'h7F : 7'h00;
  localparam logic [2:0]     AN_MASCARA  = ATIVO_BAIXO ? 3'b111 : 3'b000;

  logic [CW-1:0] contador_r;
  indice_t       indice_r;
  logic [3:0]    sombra_c_r;
  logic [3:0]    sombra_d_r;
  logic [3:0]    sombra_u_r;
  logic [6:0]    seg_r;
  logic [2:0]    an_r;

  logic          tick_s;
  indice_t       indice_prox_s;
  logic [3:0]    digito_s;
  logic [6:0]    seg_dec_s;
  logic [2:0]    an_onehot_s;
  logic          apagar_lzb_s;
  logic [6:0]    seg_prox_s;
  logic [2:0]    an_prox_s;

  assign tick_s = (contador_r == CONT_MAX);

  // Shadow register: captures the converter digits on the load strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      sombra_c_r <= 4'd0;
      sombra_d_r <= 4'd0;
      sombra_u_r <= 4'd0;
    end else if (bus.carregar) begin
      sombra_c_r <= bus.centenas;
      sombra_d_r <= bus.dezenas;
      sombra_u_r <= bus.unidades;
    end else begin
      sombra_c_r <= sombra_c_r;
      sombra_d_r <= sombra_d_r;
      sombra_u_r <= sombra_u_r;
    end
  end

  // Prescaler: free-running 0..DIVISOR-1
  always_ff @(posedge clock) begin
    if (reset) begin
      contador_r <= '0;
    end else if (tick_s) begin
      contador_r <= '0;
    end else begin
      contador_r <= contador_r + CW'(1);
    end
  end

  // Next digit in the scan order
  always_comb begin
    indice_prox_s = DIG_UNIDADES;
    case (indice_r)
      DIG_UNIDADES: indice_prox_s = DIG_DEZENAS;
      DIG_DEZENAS:  indice_prox_s = DIG_CENTENAS;
      DIG_CENTENAS: indice_prox_s = DIG_UNIDADES;
      default:      indice_prox_s = DIG_UNIDADES;
    endcase
  end

  // Digit index register; advances together with the blank cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      indice_r <= DIG_UNIDADES;
    end else if (tick_s) begin
      indice_r <= indice_prox_s;
    end else begin
      indice_r <= indice_r;
    end
  end

  // Select the shadow digit and its anode for the current slot
  always_comb begin
    digito_s    = sombra_u_r;
    an_onehot_s = AN_APAGADO;
    case (indice_r)
      DIG_UNIDADES: begin
        digito_s    = sombra_u_r;
        an_onehot_s = 3'b001;
      end
      DIG_DEZENAS: begin
        digito_s    = sombra_d_r;
        an_onehot_s = 3'b010;
      end
      DIG_CENTENAS: begin
        digito_s    = sombra_c_r;
        an_onehot_s = 3'b100;
      end
      default: begin
        digito_s    = sombra_u_r;
        an_onehot_s = AN_APAGADO;
      end
    endcase
  end

  decodificador_7seg u_decodificador (
    .bcd       (digito_s),
    .segmentos (seg_dec_s)
  );

`ifdef VARREDURA_LZB_EN
  // Leading-zero blanking: a slot goes dark when it and every higher digit are zero
  always_comb begin
    apagar_lzb_s = 1'b0;
    case (indice_r)
      DIG_CENTENAS: apagar_lzb_s = (sombra_c_r == 4'd0);
      DIG_DEZENAS:  apagar_lzb_s = (sombra_c_r == 4'd0) && (sombra_d_r == 4'd0);
      DIG_UNIDADES: apagar_lzb_s = 1'b0;
      default:      apagar_lzb_s = 1'b0;
    endcase
  end
`else
  assign apagar_lzb_s = 1'b0;
`endif

  // Internal active-high pin values for the next edge
  always_comb begin
    seg_prox_s = SEG_APAGADO;
    an_prox_s  = AN_APAGADO;
    if (tick_s || apagar_lzb_s) begin
      seg_prox_s = SEG_APAGADO;
      an_prox_s  = AN_APAGADO;
    end else begin
      seg_prox_s = seg_dec_s;
      an_prox_s  = an_onehot_s;
    end
  end

  // Output registers with pin polarity applied
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_r <= SEG_MASCARA;
      an_r  <= AN_MASCARA;
    end else begin
      seg_r <= seg_prox_s ^ SEG_MASCARA;
      an_r  <= an_prox_s ^ AN_MASCARA;
    end
  end

  assign bus.segmentos = seg_r;
  assign bus.anodos    = an_r;

endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display
// Two scanners (DIVISOR=4): dut0 with active-high pins, dut1 with
// active-low pins, fed from the same digit bus. A slot/position model
// predicts the pins every cycle; literal checks pin the model down.
module tb_varredura_display;

  localparam int DIV = 4;

  logic clk;
  logic rst;

  varredura_display_if if0 ();
  varredura_display_if if1 ();

  assign if1.carregar = if0.carregar;
  assign if1.centenas = if0.centenas;
  assign if1.dezenas  = if0.dezenas;
  assign if1.unidades = if0.unidades;

  varredura_display #(.DIVISOR(DIV), .ATIVO_BAIXO(1'b0)) dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (if0)
  );

  varredura_display #(.DIVISOR(DIV), .ATIVO_BAIXO(1'b1)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  function automatic logic [6:0] seg_de(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference model: position k since reset gives slot and phase directly
  int         k;
  logic [3:0] sh [3];
  logic [2:0] exp_an;
  logic [6:0] exp_seg;
  bit         valido;

  initial begin
    int fase;
    int dig;
    bit vazio;
    valido  = 1'b0;
    k       = 0;
    sh[0]   = 4'd0;
    sh[1]   = 4'd0;
    sh[2]   = 4'd0;
    exp_an  = 3'b000;
    exp_seg = 7'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_an  = 3'b000;
        exp_seg = 7'h00;
        k       = 0;
        sh[0]   = 4'd0;
        sh[1]   = 4'd0;
        sh[2]   = 4'd0;
      end else begin
        fase  = k % DIV;
        dig   = (k / DIV) % 3;
        vazio = (fase == DIV - 1);
`ifdef VARREDURA_LZB_EN
        if (dig == 2 && sh[2] == 4'd0) vazio = 1'b1;
        if (dig == 1 && sh[2] == 4'd0 && sh[1] == 4'd0) vazio = 1'b1;
`endif
        if (vazio) begin
          exp_an  = 3'b000;
          exp_seg = 7'h00;
        end else begin
          exp_an  = 3'b001 << dig;
          exp_seg = seg_de(sh[dig]);
        end
        k++;
        if (if0.carregar) begin
          sh[0] = if0.unidades;
          sh[1] = if0.dezenas;
          sh[2] = if0.centenas;
        end
      end
      valido = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (valido) begin
        chk("dut0 anodos",    {13'd0, if0.anodos},    {13'd0, exp_an});
        chk("dut0 segmentos", {9'd0,  if0.segmentos}, {9'd0,  exp_seg});
        chk("dut1 anodos",    {13'd0, if1.anodos},    {13'd0, ~exp_an});
        chk("dut1 segmentos", {9'd0,  if1.segmentos}, {9'd0,  ~exp_seg});
      end
    end
  end

  task automatic carga(input logic c, input logic [3:0] cen, input logic [3:0] dez, input logic [3:0] uni);
    if0.carregar = c;
    if0.centenas = cen;
    if0.dezenas  = dez;
    if0.unidades = uni;
  endtask

  task automatic lit0(input string nome, input logic [2:0] an, input logic [6:0] seg);
    chk({nome, " an"},  {13'd0, if0.anodos},    {13'd0, an});
    chk({nome, " seg"}, {9'd0,  if0.segmentos}, {9'd0,  seg});
  endtask

  logic [2:0] pat_an  [12];
  logic [6:0] pat_seg [12];
  logic [2:0] lz_an   [8];
  logic [6:0] lz_seg  [8];

  // Directed sequence with literal expectations, then random traffic
  initial begin
    pat_an  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000,
                3'b100, 3'b100, 3'b100, 3'b000};
    pat_seg = '{7'h6D, 7'h6D, 7'h6D, 7'h00, 7'h6D, 7'h6D, 7'h6D, 7'h00,
                7'h5B, 7'h5B, 7'h5B, 7'h00};
`ifdef VARREDURA_LZB_EN
    lz_an  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    lz_seg = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`else
    lz_an  = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000};
    lz_seg = '{7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h00};
`endif

    rst = 1'b1;
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    lit0("reset", 3'b000, 7'h00);
    chk("reset dut1 an",  {13'd0, if1.anodos},    16'h0007);
    chk("reset dut1 seg", {9'd0,  if1.segmentos}, 16'h007F);
    rst = 1'b0;

    @(negedge clk);                       // edge k=0
    lit0("first edge", 3'b001, 7'h3F);
    carga(1'b1, 4'd2, 4'd5, 4'd5);
    @(negedge clk);                       // edge k=1 loads 2/5/5
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    repeat (10) @(negedge clk);           // through edge k=11
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);                     // edges k=12..23
      lit0($sformatf("scan255[%0d]", i), pat_an[i], pat_seg[i]);
    end

    carga(1'b1, 4'd2, 4'd5, 4'd12);
    @(negedge clk);                       // edge 24 loads
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);                       // edge 25
    lit0("invalid digit", 3'b001, 7'h40);

    @(negedge clk);                       // edge 26
    carga(1'b1, 4'd1, 4'd2, 4'd3);
    @(negedge clk);                       // edge 27: tick and load together
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    lit0("load on tick", 3'b000, 7'h00);
    @(negedge clk);                       // edge 28: tens slot, new value
    lit0("after tick load", 3'b010, 7'h5B);
    rst = 1'b1;
    @(negedge clk);
    lit0("mid-slot reset", 3'b000, 7'h00);
    rst = 1'b0;
    @(negedge clk);
    lit0("restart units", 3'b001, 7'h3F);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      carga(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11)),
            ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11)),
            4'($urandom_range(0, 15)));
      @(negedge clk);
    end

    rst = 1'b1;
    carga(1'b1, 4'd9, 4'd9, 4'd9);        // discarded: coincides with reset
    @(negedge clk);
    rst = 1'b0;
    carga(1'b1, 4'd0, 4'd0, 4'd7);
    @(negedge clk);                       // edge k=0 loads 0/0/7
    lit0("load after reset", 3'b001, 7'h3F);
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);                       // edge k=1
    lit0("units 7", 3'b001, 7'h07);
    repeat (2) @(negedge clk);            // edges 2,3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);                     // edges 4..11
      lit0($sformatf("lzb[%0d]", i), lz_an[i], lz_seg[i]);
    end

    carga(1'b1, 4'd0, 4'd0, 4'd8);
    @(negedge clk);                       // edge 12 loads 0/0/8
    carga(1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);                       // edge 13
    chk("polarity lit an",  {13'd0, if1.anodos},    16'h0006);
    chk("polarity lit seg", {9'd0,  if1.segmentos}, 16'h0000);
    repeat (2) @(negedge clk);            // edge 15, blank
    chk("polarity blank an",  {13'd0, if1.anodos},    16'h0007);
    chk("polarity blank seg", {9'd0,  if1.segmentos}, 16'h007F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
